shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: iterates single-bit logical, arithmetic or rotate
// shifts over a held 16-bit operand and pulses done with the result and last bit out.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic             carry_nxt;
  logic             fill;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      dir_q  <= dir_nxt;
      mode_q <= mode_nxt;
      carry  <= carry_nxt;
      busy   <= (state_nxt == SHIFT);
      done   <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    mode_nxt  = mode_q;
    carry_nxt = carry;
    fill      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sreg_nxt  = op_a;
          cnt_nxt   = amt;
          dir_nxt   = dir;
          mode_nxt  = mode;
          carry_nxt = 1'b0;
          state_nxt = (amt != '0) ? SHIFT : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end

      SHIFT: begin
        // Reserved mode 11 falls through to the logical path
        if (mode_q == MODE_ROTATE) begin
          sreg_nxt = dir_q ? {sreg[0], sreg[WIDTH-1:1]}
                           : {sreg[WIDTH-2:0], sreg[WIDTH-1]};
        end else if (dir_q) begin
          fill     = (mode_q == MODE_ARITH) ? sreg[WIDTH-1] : 1'b0;
          sreg_nxt = {fill, sreg[WIDTH-1:1]};
        end else begin
          sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
        end
        carry_nxt = dir_q ? sreg[0] : sreg[WIDTH-1];
        cnt_nxt   = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign result = sreg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a scoreboard queue holds expected result,
// carry and done latency per request; a monitor pops and checks on every done.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [3:0]  amt;
  logic        dir;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] res;
    logic        c;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .amt    (amt),
    .dir    (dir),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-amount shift in one step, carry is the last bit that left
  function automatic logic [16:0] model(input logic [15:0] a, input int n,
                                        input logic d, input logic [1:0] m);
    logic [15:0] r;
    logic        c;
    if (n == 0) return {1'b0, a};
    if (m == 2'b10) begin
      if (!d) begin
        r = (a << n) | (a >> (16 - n));
        c = r[0];
      end else begin
        r = (a >> n) | (a << (16 - n));
        c = r[15];
      end
    end else if (!d) begin
      r = a << n;
      c = a[16 - n];
    end else begin
      r = (m == 2'b01) ? 16'($signed(a) >>> n) : (a >> n);
      c = a[n - 1];
    end
    return {c, r};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      checks++;
      assert (sbq.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_done observed=1 expected=0 cyc=%0d", cyc);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        assert (result === e.res) else begin
          failures++;
          $error("FAIL result observed=%h expected=%h", result, e.res);
        end
        checks++;
        assert (carry === e.c) else begin
          failures++;
          $error("FAIL carry observed=%b expected=%b", carry, e.c);
        end
        checks++;
        assert ((cyc - e.issue) === e.lat) else begin
          failures++;
          $error("FAIL done_latency observed=%0d expected=%0d", cyc - e.issue, e.lat);
        end
      end
    end
  end

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  // Drive one request at a negedge; returns at the negedge of cycle 1
  task automatic issue(input logic [15:0] a, input logic [3:0] n,
                       input logic d, input logic [1:0] m);
    logic [16:0] r;
    exp_t        e;
    r       = model(a, int'(n), d, m);
    e.res   = r[15:0];
    e.c     = r[16];
    e.issue = cyc;
    e.lat   = int'(n) + 1;
    sbq.push_back(e);
    start = 1'b1;
    op_a  = a;
    amt   = n;
    dir   = d;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    op_a  = 16'($urandom);
    amt   = 4'($urandom);
    dir   = 1'($urandom);
    mode  = 2'($urandom);
  endtask

  // Full request with busy checked every cycle up to the done cycle
  task automatic run(input logic [15:0] a, input logic [3:0] n,
                     input logic d, input logic [1:0] m);
    issue(a, n, d, m);
    for (int k = 1; k <= int'(n) + 1; k++) begin
      chk_bit("busy", busy, k <= int'(n));
      chk_bit("done", done, k == int'(n) + 1);
      if (k <= int'(n)) @(negedge clk);
    end
    @(negedge clk);
    chk_bit("done_after", done, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    amt   = '0;
    dir   = 1'b0;
    mode  = 2'b00;
    repeat (3) @(negedge clk);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_carry", carry, 1'b0);
    checks++;
    assert (result === 16'h0000) else begin
      failures++;
      $error("FAIL rst_result observed=%h expected=0000", result);
    end
    rst = 1'b0;
    @(negedge clk);

    run(16'h0001, 4'd4,  1'b0, 2'b00);
    run(16'h8000, 4'd3,  1'b1, 2'b01);
    run(16'hFFFF, 4'd15, 1'b1, 2'b00);
    run(16'h8001, 4'd1,  1'b0, 2'b10);
    run(16'h0001, 4'd1,  1'b1, 2'b10);
    run(16'hF0F1, 4'd3,  1'b0, 2'b11);
    run(16'h8F08, 4'd4,  1'b1, 2'b11);
    run(16'hC003, 4'd2,  1'b0, 2'b01);
    run(16'h1234, 4'd15, 1'b0, 2'b10);
    run(16'hABCD, 4'd0,  1'b0, 2'b00);

    // start during SHIFT with new operands must be ignored
    issue(16'h00F0, 4'd5, 1'b0, 2'b00);
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h5555;
    amt   = 4'd1;
    dir   = 1'b1;
    mode  = 2'b10;
    @(negedge clk);
    start = 1'b0;
    chk_bit("busy_ignored_start", busy, 1'b1);
    repeat (3) @(negedge clk);
    chk_bit("done_ignored_start", done, 1'b1);
    @(negedge clk);

    // Back-to-back: second start in the first done cycle
    issue(16'h0F0F, 4'd3, 1'b1, 2'b01);
    repeat (3) @(negedge clk);
    chk_bit("done_b2b_first", done, 1'b1);
    issue(16'hA5A5, 4'd2, 1'b0, 2'b10);
    chk_bit("busy_b2b_second", busy, 1'b1);
    @(negedge clk);
    chk_bit("done_b2b_second", done, 1'b0);
    @(negedge clk);
    chk_bit("done_b2b_second", done, 1'b1);
    issue(16'h7777, 4'd0, 1'b0, 2'b00);
    chk_bit("done_b2b_zero", done, 1'b1);
    @(negedge clk);

    // Asynchronous reset in cycle 3 of an amt=8 job
    issue(16'h1357, 4'd8, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk_bit("abort_carry", carry, 1'b0);
    checks++;
    assert (result === 16'h0000) else begin
      failures++;
      $error("FAIL abort_result observed=%h expected=0000", result);
    end
    void'(sbq.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run(16'h2468, 4'd6, 1'b1, 2'b00);

    repeat (4) @(negedge clk);
    checks++;
    assert (sbq.size() == 0) else begin
      failures++;
      $error("FAIL pending_jobs observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
